// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the ALU execution unit: control codes and FSM state encodings.
package alu_exec_unit_pkg;

  localparam int unsigned NOP_CTRL  = 0;
  localparam int unsigned ADD_CTRL  = 1;
  localparam int unsigned SUB_CTRL  = 2;
  localparam int unsigned AND_CTRL  = 3;
  localparam int unsigned OR_CTRL   = 4;
  localparam int unsigned XOR_CTRL  = 5;
  localparam int unsigned SLL_CTRL  = 6;
  localparam int unsigned SRL_CTRL  = 7;
  localparam int unsigned SRA_CTRL  = 8;
  localparam int unsigned SLT_CTRL  = 9;
  localparam int unsigned SLTU_CTRL = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_exec_unit_shift_iter.sv
// Iterative shifter: one bit position per cycle, loaded with operand and shift amount.
module alu_shift_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            dir,
  input  logic            arith,
  input  logic [XLEN-1:0] data_i,
  input  logic [4:0]      shamt_i,
  output logic [XLEN-1:0] nxt_o,
  output logic            done
);

  logic [XLEN-1:0] sreg_q;
  logic [4:0]      cnt_q;

  // dir=1 shifts right; arith replicates the sign bit on right shifts
  assign nxt_o = dir ? {arith & sreg_q[XLEN-1], sreg_q[XLEN-1:1]}
                     : {sreg_q[XLEN-2:0], 1'b0};
  // nxt_o holds the final value on the edge the count drops to zero
  assign done  = (cnt_q == 5'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= data_i;
      cnt_q  <= shamt_i;
    end else if (cnt_q != 5'd0) begin
      sreg_q <= nxt_o;
      cnt_q  <= cnt_q - 5'd1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic ops, iterative shifts, valid/ready handshakes.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              sh_load, sh_done, sh_dir, sh_arith;
  logic [XLEN-1:0]   sh_nxt;

  function automatic logic is_shift(input logic [CTRL_W-1:0] c);
    return (c == CTRL_W'(SLL_CTRL)) || (c == CTRL_W'(SRL_CTRL)) || (c == CTRL_W'(SRA_CTRL));
  endfunction

  // Shift codes land here only with a zero shift amount, which passes op_a through
  function automatic logic [XLEN-1:0] alu_f(input logic [CTRL_W-1:0] c,
                                            input logic [XLEN-1:0] a, b);
    case (c)
      CTRL_W'(ADD_CTRL):  return a + b;
      CTRL_W'(SUB_CTRL):  return a - b;
      CTRL_W'(AND_CTRL):  return a & b;
      CTRL_W'(OR_CTRL):   return a | b;
      CTRL_W'(XOR_CTRL):  return a ^ b;
      CTRL_W'(SLL_CTRL),
      CTRL_W'(SRL_CTRL),
      CTRL_W'(SRA_CTRL):  return a;
      CTRL_W'(SLT_CTRL):  return XLEN'($signed(a) < $signed(b));
      CTRL_W'(SLTU_CTRL): return XLEN'(a < b);
      default:            return '0;
    endcase
  endfunction

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign sh_dir    = (ctrl_q == CTRL_W'(SRL_CTRL)) || (ctrl_q == CTRL_W'(SRA_CTRL));
  assign sh_arith  = (ctrl_q == CTRL_W'(SRA_CTRL));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ctrl_d   = ctrl_q;
    sh_load  = 1'b0;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        ctrl_d = alu_ctrl;
        if (is_shift(alu_ctrl) && (op_b[4:0] != 5'd0)) begin
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          result_d = alu_f(alu_ctrl, op_a, op_b);
          state_d  = ST_DONE;
        end
      end
      ST_SHIFT: if (sh_done) begin
        result_d = sh_nxt;
        state_d  = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ctrl_q   <= ctrl_d;
    end
  end

  alu_shift_iter #(.XLEN(XLEN)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sh_load),
    .dir     (sh_dir),
    .arith   (sh_arith),
    .data_i  (op_a),
    .shamt_i (op_b[4:0]),
    .nxt_o   (sh_nxt),
    .done    (sh_done)
  );

endmodule
